mem_stage_ctrl: RTL and testbench

Sequencer for the MEM stage that sits beside the EX/MEM pipeline register. It turns the registered memory-stage controls (`mem_to_reg_m`, `mem_write_m`, `alu_result_m`, `write_data_m`, `syscall_m`) into a single-outstanding valid/ack transaction on the data-memory port. While an access is in flight it stalls the front of the pipeline and bubbles MEM/WB. It also latches a halt on syscall, and a sticky error on a misaligned address or a memory timeout.

---
 rtl/mem_stage_ctrl.sv | 125 ++++++++++++
 tb/tb_mem_stage_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: turns EX/MEM memory controls into one outstanding
// valid/ack data-memory transaction, stalls the front end while it is in
// flight, and latches sticky halt (syscall) and bus-error conditions.
module mem_stage_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_to_reg_m,
  input  logic        mem_write_m,
  input  logic        syscall_m,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] write_data_m,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        stall_em,
  output logic        bubble_mw,
  output logic [31:0] read_data_m,
  output logic        halted,
  output logic        bus_error
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_HALT,
    S_ERR
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic          mem_op;
  logic          misaligned;
  logic          timeout_hit;

  // A store wins when both load and store flags are set (dmem_we follows mem_write_m).
  assign mem_op      = mem_to_reg_m | mem_write_m;
  assign misaligned  = |alu_result_m[1:0];
  // This WAIT cycle is the TIMEOUT-th one when the counter still reads TIMEOUT-1.
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));
  assign bubble_mw   = stall_em;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state decode and the combinational front-end stall.
  always_comb begin
    state_n  = state;
    stall_em = 1'b0;
    unique case (state)
      S_IDLE: begin
        stall_em = mem_op | syscall_m;
        if (syscall_m) begin
          state_n = S_HALT;
        end else if (mem_op && misaligned) begin
          state_n = S_ERR;
        end else if (mem_op) begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        stall_em = 1'b1;
        if (dmem_ack) begin
          state_n = S_DONE;
        end else if (timeout_hit) begin
          state_n = S_ERR;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      S_HALT, S_ERR: begin
        stall_em = 1'b1;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Registered memory-port, status, load-data and timeout-counter outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      read_data_m <= '0;
      halted      <= 1'b0;
      bus_error   <= 1'b0;
      cnt         <= '0;
    end else begin
      dmem_req  <= (state_n == S_WAIT);
      halted    <= (state_n == S_HALT);
      bus_error <= (state_n == S_ERR);
      if ((state == S_IDLE) && (state_n == S_WAIT)) begin
        dmem_addr  <= alu_result_m;
        dmem_wdata <= write_data_m;
        dmem_we    <= mem_write_m;
        cnt        <= '0;
      end else if ((state == S_WAIT) && !dmem_ack && (cnt != {CW{1'b1}})) begin
        cnt <= cnt + CW'(1);
      end
      if ((state == S_WAIT) && dmem_ack && !dmem_we) begin
        read_data_m <= DW'(dmem_rdata);
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed memory ops, request/load-data scoreboard.
module tb_mem_stage_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_to_reg_m, mem_write_m, syscall_m;
  logic [31:0] alu_result_m, write_data_m;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        stall_em, bubble_mw;
  logic [31:0] read_data_m;
  logic        halted, bus_error;

  int checks   = 0;
  int failures = 0;

  logic [64:0] req_q[$];
  logic [31:0] done_q[$];
  logic [31:0] exp_rd = 32'h0;

  mem_stage_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_to_reg_m(mem_to_reg_m), .mem_write_m(mem_write_m), .syscall_m(syscall_m),
    .alu_result_m(alu_result_m), .write_data_m(write_data_m),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .stall_em(stall_em), .bubble_mw(bubble_mw), .read_data_m(read_data_m),
    .halted(halted), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every request cycle and every DONE cycle pops an expectation.
  logic prev_req = 1'b0;
  logic prev_rst = 1'b0;
  always @(negedge clk) begin
    if (dmem_req) begin
      if (req_q.size() == 0) begin
        chk("unexpected_req", {dmem_we, dmem_addr, dmem_wdata}, 65'h0);
      end else begin
        chk("req_payload", {dmem_we, dmem_addr, dmem_wdata}, req_q.pop_front());
      end
    end
    if (rst_n && prev_rst && prev_req && !dmem_req && !stall_em) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", 65'(read_data_m), 65'h1_0000_0000);
      end else begin
        chk("done_read_data", 65'(read_data_m), 65'(done_q.pop_front()));
      end
    end
    prev_req = dmem_req;
    prev_rst = rst_n;
  end

  task automatic clear_inputs();
    mem_to_reg_m = 1'b0; mem_write_m = 1'b0; syscall_m = 1'b0;
    alu_result_m = 32'h0; write_data_m = 32'h0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
  endtask

  // Hold one instruction in MEM until stall drops (or max_cyc expires), counting cycles.
  task automatic run_mem(input string name, input logic ld, input logic st, input logic sc,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int ack_at, input logic [31:0] rdata, input int max_cyc,
                         input int exp_stall, input int exp_req, input int exp_err,
                         input int exp_halt);
    int stall_cnt = 0, req_cnt = 0, err_cnt = 0, halt_cnt = 0, cyc = 0;
    bit done = 1'b0;
    for (int i = 0; i < exp_req; i++) req_q.push_back({st, addr, wdata});
    if (ack_at > 0) begin
      if (ld && !st) exp_rd = rdata;
      done_q.push_back(exp_rd);
    end
    @(posedge clk); #1;
    mem_to_reg_m = ld; mem_write_m = st; syscall_m = sc;
    alu_result_m = addr; write_data_m = wdata;
    while (!done && cyc < max_cyc) begin
      dmem_ack   = (ack_at > 0) && (cyc == ack_at);
      dmem_rdata = dmem_ack ? rdata : 32'hBAD0_BAD0;
      @(negedge clk);
      if (stall_em) stall_cnt++; else done = 1'b1;
      if (dmem_req) req_cnt++;
      if (bus_error) err_cnt++;
      if (halted) halt_cnt++;
      @(posedge clk); #1;
      cyc++;
    end
    clear_inputs();
    chk({name, "_stall_cycles"}, 65'(stall_cnt), 65'(exp_stall));
    chk({name, "_req_cycles"}, 65'(req_cnt), 65'(exp_req));
    chk({name, "_err_cycles"}, 65'(err_cnt), 65'(exp_err));
    chk({name, "_halt_cycles"}, 65'(halt_cnt), 65'(exp_halt));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_halted", 65'(halted), 65'h0);
    chk("rst_bus_error", 65'(bus_error), 65'h0);
    chk("rst_stall", 65'(stall_em), 65'h0);
    exp_rd = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #2;
    chk("reset_req", 65'(dmem_req), 65'h0);
    chk("reset_payload", {dmem_we, dmem_addr, dmem_wdata}, 65'h0);
    chk("reset_rdata", 65'(read_data_m), 65'h0);
    chk("reset_status", {63'h0, halted, bus_error}, 65'h0);
    chk("reset_stall_idle", {63'h0, stall_em, bubble_mw}, 65'h0);
    mem_to_reg_m = 1'b1; #1;
    chk("reset_stall_memop", {63'h0, stall_em, bubble_mw}, 65'h3);
    mem_to_reg_m = 1'b0; syscall_m = 1'b1; #1;
    chk("reset_stall_syscall", {63'h0, stall_em, bubble_mw}, 65'h3);
    syscall_m = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Non-memory instruction: no stall.
    @(posedge clk); #1; alu_result_m = 32'h103;
    @(negedge clk);
    chk("nonmem_stall", {63'h0, stall_em, bubble_mw}, 65'h0);
    chk("nonmem_req", 65'(dmem_req), 65'h0);
    clear_inputs();

    // Load 0x100, ack in 2nd WAIT cycle.
    run_mem("load", 1, 0, 0, 32'h100, 32'h0, 2, 32'hDEAD_BEEF, 20, 3, 2, 0, 0);
    // Store 0x20, ack in 1st WAIT cycle; read data unchanged.
    run_mem("store", 0, 1, 0, 32'h20, 32'h1234, 1, 32'h5555_5555, 20, 2, 1, 0, 0);
    // Load+store flags together behave as store.
    run_mem("both", 1, 1, 0, 32'h40, 32'h55, 1, 32'h7777_7777, 20, 2, 1, 0, 0);
    // Back-to-back loads.
    run_mem("load2", 1, 0, 0, 32'h104, 32'h0, 1, 32'hCAFE_F00D, 20, 2, 1, 0, 0);
    run_mem("load3", 1, 0, 0, 32'h108, 32'h0, 3, 32'h0123_4567, 20, 4, 3, 0, 0);
    // Ack in the TIMEOUT-th cycle wins over the timeout.
    run_mem("ack_at_to", 0, 1, 0, 32'h80, 32'hA5A5, 4, 32'h0, 20, 5, 4, 0, 0);
    chk("ack_at_to_noerr", 65'(bus_error), 65'h0);

    // Reset mid-WAIT: req drops immediately, stray ack afterwards ignored.
    req_q.push_back({1'b0, 32'h200, 32'h0});
    @(posedge clk); #1; mem_to_reg_m = 1'b1; alu_result_m = 32'h200;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midwait_req_before", 65'(dmem_req), 65'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("midwait_req_dropped", 65'(dmem_req), 65'h0);
    chk("midwait_payload", {dmem_we, dmem_addr, dmem_wdata}, 65'h0);
    chk("midwait_rdata", 65'(read_data_m), 65'h0);
    chk("midwait_stall_in_rst", 65'(stall_em), 65'h1);
    clear_inputs();
    exp_rd = 32'h0;
    @(negedge clk);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1; dmem_ack = 1'b1; dmem_rdata = 32'h1111_1111;
    @(negedge clk);
    chk("stray_ack_idle", {62'h0, stall_em, dmem_req, halted}, 65'h0);
    @(posedge clk); #1; dmem_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_rdata", 65'(read_data_m), 65'h0);

    // Misaligned load: error the next cycle, no request, stall held.
    run_mem("misalign", 1, 0, 0, 32'h102, 32'h0, 0, 32'h0, 6, 6, 0, 5, 0);
    do_reset();
    // Store with no ack: 4 request cycles then error.
    run_mem("timeout", 0, 1, 0, 32'h60, 32'h99, 0, 32'h0, 10, 10, TO, 5, 0);
    do_reset();
    // Syscall with a load: halt, no request; later ack ignored.
    run_mem("syscall", 1, 0, 1, 32'h100, 32'h0, 0, 32'h0, 6, 6, 0, 0, 5);
    @(posedge clk); #1; dmem_ack = 1'b1; dmem_rdata = 32'h2222_2222;
    @(posedge clk); #1; dmem_ack = 1'b0;
    @(negedge clk);
    chk("halt_ack_ignored", {read_data_m, halted, stall_em}, {32'h0, 2'b11});
    do_reset();

    repeat (2) @(negedge clk);
    chk("req_q_drained", 65'(req_q.size()), 65'h0);
    chk("done_q_drained", 65'(done_q.size()), 65'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
